// File: rtl/decode_ctrl_stage.sv
// Registered main-decode stage between IF/ID and ID/EX with a valid/ready handshake,
// stall/flush hooks for the hazard unit and a saturating illegal-opcode counter.
module decode_ctrl_stage #(
  parameter int unsigned PC_W     = 32,
  parameter bit          EN_UTYPE = 1'b1,
  parameter bit          EN_JALR  = 1'b1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_regwrite,
  output logic [2:0]       out_immsrc,
  output logic             out_alusrc,
  output logic             out_alusrca,
  output logic             out_memwrite,
  output logic [1:0]       out_resultsrc,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_jumpreg,
  output logic [1:0]       out_aluop,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic             out_funct7b5,
  output logic [PC_W-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef struct packed {
    logic       regwrite;
    logic [2:0] immsrc;
    logic       alusrc;
    logic       alusrca;
    logic       memwrite;
    logic [1:0] resultsrc;
    logic       branch;
    logic       jump;
    logic       jumpreg;
    logic [1:0] aluop;
    logic       illegal;
  } ctl_t;

  localparam ctl_t CtlIllegal = '{illegal: 1'b1, default: '0};

  ctl_t             w_dec;
  logic             w_xfer;
  ctl_t             r_ctl;
  logic             r_valid;
  logic [4:0]       r_rd, r_rs1, r_rs2;
  logic [2:0]       r_funct3;
  logic             r_funct7b5;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_dec = '0;
    unique case (in_instr[6:0])
      7'b0000011: w_dec = '{1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
      7'b0100011: w_dec = '{1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
      7'b0110011: w_dec = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0};
      7'b1100011: w_dec = '{1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0};
      7'b0010011: w_dec = '{1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0};
      7'b1101111: w_dec = '{1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
      7'b1100111: begin
        if (EN_JALR) begin
          w_dec = '{1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0};
        end else begin
          w_dec = CtlIllegal;
        end
      end
      7'b0110111: begin
        if (EN_UTYPE) begin
          w_dec = '{1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        end else begin
          w_dec = CtlIllegal;
        end
      end
      7'b0010111: begin
        if (EN_UTYPE) begin
          w_dec = '{1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        end else begin
          w_dec = CtlIllegal;
        end
      end
      default: w_dec = CtlIllegal;
    endcase
  end

  assign in_ready = !stall && (!r_valid || out_ready);
  assign w_xfer   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_ctl      <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_pc       <= '0;
      r_cnt      <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctl   <= '0;
    end else if (stall) begin
      r_valid <= r_valid;
    end else if (w_xfer) begin
      r_valid    <= 1'b1;
      r_ctl      <= w_dec;
      r_rd       <= in_instr[11:7];
      r_rs1      <= in_instr[19:15];
      r_rs2      <= in_instr[24:20];
      r_funct3   <= in_instr[14:12];
      r_funct7b5 <= in_instr[30];
      r_pc       <= in_pc;
      // Saturate rather than wrap so a flood of bad opcodes stays visible.
      if (w_dec.illegal && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
      r_ctl   <= '0;
    end
  end

  assign out_valid     = r_valid;
  assign out_regwrite  = r_ctl.regwrite;
  assign out_immsrc    = r_ctl.immsrc;
  assign out_alusrc    = r_ctl.alusrc;
  assign out_alusrca   = r_ctl.alusrca;
  assign out_memwrite  = r_ctl.memwrite;
  assign out_resultsrc = r_ctl.resultsrc;
  assign out_branch    = r_ctl.branch;
  assign out_jump      = r_ctl.jump;
  assign out_jumpreg   = r_ctl.jumpreg;
  assign out_aluop     = r_ctl.aluop;
  assign out_illegal   = r_ctl.illegal;
  assign out_rd        = r_rd;
  assign out_rs1       = r_rs1;
  assign out_rs2       = r_rs2;
  assign out_funct3    = r_funct3;
  assign out_funct7b5  = r_funct7b5;
  assign out_pc        = r_pc;
  assign illegal_count = r_cnt;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: default, CNT_W=2 and U-type/JALR-disabled
// instances share one stimulus stream; control bundles compare as 15-bit vectors.
module tb_decode_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush, out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;

  // Default instance outputs.
  logic        d_in_ready, d_valid, d_regwrite, d_alusrc, d_alusrca, d_memwrite;
  logic        d_branch, d_jump, d_jumpreg, d_f7b5, d_illegal;
  logic [2:0]  d_immsrc, d_f3;
  logic [1:0]  d_resultsrc, d_aluop;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic [31:0] d_pc;
  logic [7:0]  d_cnt;
  // CNT_W=2 instance outputs.
  logic        s_in_ready, s_valid, s_regwrite, s_alusrc, s_alusrca, s_memwrite;
  logic        s_branch, s_jump, s_jumpreg, s_f7b5, s_illegal;
  logic [2:0]  s_immsrc, s_f3;
  logic [1:0]  s_resultsrc, s_aluop;
  logic [4:0]  s_rd, s_rs1, s_rs2;
  logic [31:0] s_pc;
  logic [1:0]  s_cnt;
  // Gated (EN_UTYPE=0, EN_JALR=0) instance outputs.
  logic        g_in_ready, g_valid, g_regwrite, g_alusrc, g_alusrca, g_memwrite;
  logic        g_branch, g_jump, g_jumpreg, g_f7b5, g_illegal;
  logic [2:0]  g_immsrc, g_f3;
  logic [1:0]  g_resultsrc, g_aluop;
  logic [4:0]  g_rd, g_rs1, g_rs2;
  logic [31:0] g_pc;
  logic [7:0]  g_cnt;

  logic [14:0] d_ctl, s_ctl, g_ctl;
  assign d_ctl = {d_regwrite, d_immsrc, d_alusrc, d_alusrca, d_memwrite, d_resultsrc,
                  d_branch, d_jump, d_jumpreg, d_aluop, d_illegal};
  assign s_ctl = {s_regwrite, s_immsrc, s_alusrc, s_alusrca, s_memwrite, s_resultsrc,
                  s_branch, s_jump, s_jumpreg, s_aluop, s_illegal};
  assign g_ctl = {g_regwrite, g_immsrc, g_alusrc, g_alusrca, g_memwrite, g_resultsrc,
                  g_branch, g_jump, g_jumpreg, g_aluop, g_illegal};

  decode_ctrl_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .stall(stall), .flush(flush), .out_valid(d_valid), .out_ready(out_ready),
    .out_regwrite(d_regwrite), .out_immsrc(d_immsrc), .out_alusrc(d_alusrc),
    .out_alusrca(d_alusrca), .out_memwrite(d_memwrite), .out_resultsrc(d_resultsrc),
    .out_branch(d_branch), .out_jump(d_jump), .out_jumpreg(d_jumpreg), .out_aluop(d_aluop),
    .out_rd(d_rd), .out_rs1(d_rs1), .out_rs2(d_rs2), .out_funct3(d_f3),
    .out_funct7b5(d_f7b5), .out_pc(d_pc), .out_illegal(d_illegal), .illegal_count(d_cnt)
  );

  decode_ctrl_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .stall(stall), .flush(flush), .out_valid(s_valid), .out_ready(out_ready),
    .out_regwrite(s_regwrite), .out_immsrc(s_immsrc), .out_alusrc(s_alusrc),
    .out_alusrca(s_alusrca), .out_memwrite(s_memwrite), .out_resultsrc(s_resultsrc),
    .out_branch(s_branch), .out_jump(s_jump), .out_jumpreg(s_jumpreg), .out_aluop(s_aluop),
    .out_rd(s_rd), .out_rs1(s_rs1), .out_rs2(s_rs2), .out_funct3(s_f3),
    .out_funct7b5(s_f7b5), .out_pc(s_pc), .out_illegal(s_illegal), .illegal_count(s_cnt)
  );

  decode_ctrl_stage #(.EN_UTYPE(1'b0), .EN_JALR(1'b0)) dut_gate (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(g_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .stall(stall), .flush(flush), .out_valid(g_valid), .out_ready(out_ready),
    .out_regwrite(g_regwrite), .out_immsrc(g_immsrc), .out_alusrc(g_alusrc),
    .out_alusrca(g_alusrca), .out_memwrite(g_memwrite), .out_resultsrc(g_resultsrc),
    .out_branch(g_branch), .out_jump(g_jump), .out_jumpreg(g_jumpreg), .out_aluop(g_aluop),
    .out_rd(g_rd), .out_rs1(g_rs1), .out_rs2(g_rs2), .out_funct3(g_f3),
    .out_funct7b5(g_f7b5), .out_pc(g_pc), .out_illegal(g_illegal), .illegal_count(g_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [2:0] f3, input logic b30);
    return {1'b0, b30, 5'b0, rs2, rs1, f3, rd, op};
  endfunction

  // {regwrite, immsrc, alusrc, alusrca, memwrite, resultsrc, branch, jump, jumpreg, aluop, illegal}
  localparam logic [14:0] CtlLoad  = 15'b1_000_1_0_0_01_0_0_0_00_0;
  localparam logic [14:0] CtlStore = 15'b0_001_1_0_1_00_0_0_0_00_0;
  localparam logic [14:0] CtlIll   = 15'b0_000_0_0_0_00_0_0_0_00_1;

  logic [6:0]  ops  [9];
  logic [14:0] exps [9];
  logic [7:0]  cnt_snap;

  initial begin
    ops[0] = 7'b0000011; exps[0] = CtlLoad;
    ops[1] = 7'b0100011; exps[1] = CtlStore;
    ops[2] = 7'b0110011; exps[2] = 15'b1_000_0_0_0_00_0_0_0_10_0;
    ops[3] = 7'b1100011; exps[3] = 15'b0_010_0_0_0_00_1_0_0_01_0;
    ops[4] = 7'b0010011; exps[4] = 15'b1_000_1_0_0_00_0_0_0_10_0;
    ops[5] = 7'b1101111; exps[5] = 15'b1_011_0_0_0_10_0_1_0_00_0;
    ops[6] = 7'b1100111; exps[6] = 15'b1_000_1_0_0_10_0_1_1_00_0;
    ops[7] = 7'b0110111; exps[7] = 15'b1_100_1_0_0_11_0_0_0_00_0;
    ops[8] = 7'b0010111; exps[8] = 15'b1_100_1_1_0_00_0_0_0_00_0;

    // Reset with a valid load presented: nothing may be captured.
    rst = 1'b1; in_valid = 1'b1; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = mk(7'b0000011, 5'd1, 5'd2, 5'd3, 3'd2, 1'b0); in_pc = 32'h40;
    step(); step();
    check("rst_valid", d_valid, 0);
    check("rst_ctl", d_ctl, 0);
    check("rst_cnt", d_cnt, 0);
    check("rst_pc", d_pc, 0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    check("post_rst_valid", d_valid, 0);

    // Back-to-back decode sweep.
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_instr = mk(ops[i], 5'(i + 1), 5'(i + 10), 5'(i + 20), 3'(i), i[0]);
      in_pc    = 32'h1000 + 32'(4 * i);
      step();
      check($sformatf("sweep%0d_valid", i), d_valid, 1);
      check($sformatf("sweep%0d_ctl", i), d_ctl, exps[i]);
      check($sformatf("sweep%0d_rd", i), d_rd, i + 1);
      check($sformatf("sweep%0d_rs1", i), d_rs1, i + 10);
      check($sformatf("sweep%0d_rs2", i), d_rs2, i + 20);
      check($sformatf("sweep%0d_f3", i), d_f3, i % 8);
      check($sformatf("sweep%0d_f7b5", i), d_f7b5, i % 2);
      check($sformatf("sweep%0d_pc", i), d_pc, 32'h1000 + 4 * i);
      if (i >= 6) check($sformatf("gate%0d_ctl", i), g_ctl, CtlIll);
    end
    check("sweep_cnt", d_cnt, 0);
    check("gate_cnt", g_cnt, 3);

    // Illegal opcode flood, CNT_W=2 instance saturates at 3.
    for (int i = 0; i < 5; i++) begin
      in_instr = mk(7'b1111111, 5'd7, 5'd8, 5'd9, 3'd1, 1'b1);
      step();
      check($sformatf("ill%0d_ctl", i), s_ctl, CtlIll);
      check($sformatf("ill%0d_cnt", i), s_cnt, (i < 3) ? i + 1 : 3);
    end
    check("ill_cnt_default", d_cnt, 5);

    // Backpressure: hold A while EX is not ready, then replace with B without a gap.
    in_instr = mk(7'b0000011, 5'd11, 5'd12, 5'd13, 3'd0, 1'b0);
    step();
    out_ready = 1'b0;
    in_instr  = mk(7'b0100011, 5'd21, 5'd22, 5'd23, 3'd0, 1'b0);
    #1;
    check("bp_in_ready_lo", d_in_ready, 0);
    step();
    check("bp_hold_ctl", d_ctl, CtlLoad);
    check("bp_hold_rd", d_rd, 11);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_hi", d_in_ready, 1);
    step();
    check("bp_new_valid", d_valid, 1);
    check("bp_new_ctl", d_ctl, CtlStore);
    check("bp_new_rd", d_rd, 21);
    in_valid = 1'b0;
    step();
    check("drain_valid", d_valid, 0);
    check("drain_ctl", d_ctl, 0);

    // Stall holds a valid bundle even with out_ready=1.
    in_valid = 1'b1;
    in_instr = mk(7'b0000011, 5'd14, 5'd15, 5'd16, 3'd3, 1'b1);
    step();
    stall    = 1'b1;
    in_instr = mk(7'b0100011, 5'd24, 5'd25, 5'd26, 3'd0, 1'b0);
    #1;
    check("stall_in_ready", d_in_ready, 0);
    step();
    check("stall_valid", d_valid, 1);
    check("stall_ctl", d_ctl, CtlLoad);
    check("stall_rd", d_rd, 14);

    // Flush drops the incoming illegal opcode without counting it.
    cnt_snap = d_cnt;
    stall    = 1'b0;
    flush    = 1'b1;
    in_instr = mk(7'b1111111, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0);
    step();
    check("flush_valid", d_valid, 0);
    check("flush_regwrite", d_regwrite, 0);
    check("flush_illegal", d_illegal, 0);
    check("flush_cnt", d_cnt, cnt_snap);

    // Flush beats stall.
    flush    = 1'b0;
    in_instr = mk(7'b0010011, 5'd17, 5'd18, 5'd19, 3'd0, 1'b0);
    step();
    check("pre_fs_valid", d_valid, 1);
    flush = 1'b1;
    stall = 1'b1;
    step();
    check("fs_valid", d_valid, 0);
    check("fs_ctl", d_ctl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
- Registered, parametrised main-decode stage sitting between the IF/ID and ID/EX pipeline registers.
- Decodes the 7-bit opcode into the full control bundle and adds the U-type, AUIPC and JALR classes.
- Flags illegal opcodes and keeps a saturating illegal-opcode count.
- Registers the control bundle, register indices and PC behind a valid/ready handshake, with stall and flush inputs for the hazard unit.

Parameters:
- PC_W, 32, width of the carried PC.
- EN_UTYPE, 1, decode LUI (0110111) and AUIPC (0010111) when 1; treat them as illegal when 0.
- EN_JALR, 1, decode JALR (1100111) when 1; treat it as illegal when 0.
- CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction available from IF/ID
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  PC_W  PC of in_instr
- stall  in  1  hold stage contents (hazard unit)
- flush  in  1  kill stage contents and the incoming instruction
- out_valid  out  1  registered bundle valid
- out_ready  in  1  EX stage consumes the bundle
- out_regwrite  out  1  register-file write enable
- out_immsrc  out  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U
- out_alusrc  out  1  ALU B operand: 0 register, 1 immediate
- out_alusrca  out  1  ALU A operand: 0 rs1, 1 PC
- out_memwrite  out  1  data-memory write enable
- out_resultsrc  out  2  result select: 00 ALU, 01 memory, 10 PC+4, 11 immediate
- out_branch  out  1  conditional branch
- out_jump  out  1  unconditional jump
- out_jumpreg  out  1  jump target is rs1+imm (JALR)
- out_aluop  out  2  ALU-decoder class
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], instr[19:15], instr[24:20]
- out_funct3  out  3  instr[14:12]
- out_funct7b5  out  1  instr[30]
- out_pc  out  PC_W  registered PC
- out_illegal  out  1  opcode not supported under current parameters
- illegal_count  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Decode table, listed as regwrite, immsrc, alusrc, alusrca, memwrite, resultsrc, branch, jump, jumpreg, aluop:
  - 0000011 load: 1, 000, 1, 0, 0, 01, 0, 0, 0, 00
  - 0100011 store: 0, 001, 1, 0, 1, 00, 0, 0, 0, 00
  - 0110011 R-type: 1, 000, 0, 0, 0, 00, 0, 0, 0, 10
  - 1100011 branch: 0, 010, 0, 0, 0, 00, 1, 0, 0, 01
  - 0010011 I-ALU: 1, 000, 1, 0, 0, 00, 0, 0, 0, 10
  - 1101111 JAL: 1, 011, 0, 0, 0, 10, 0, 1, 0, 00
  - 1100111 JALR: 1, 000, 1, 0, 0, 10, 0, 1, 1, 00
  - 0110111 LUI: 1, 100, 1, 0, 0, 11, 0, 0, 0, 00
  - 0010111 AUIPC: 1, 100, 1, 1, 0, 00, 0, 0, 0, 00
  - Any other opcode, or a disabled class: all controls 0 and out_illegal=1.
- Handshake:
  - in_ready = !stall && (!out_valid || out_ready).
  - A transfer occurs when in_valid && in_ready.
  - Latency is 1 cycle: the bundle is registered on the transfer edge, and out_valid=1 from the next cycle.
- Register update priority per clock edge: rst > flush > stall > transfer > drain.
  - rst: out_valid=0, all control outputs 0, out_illegal=0, fields and out_pc 0, illegal_count=0.
  - flush: out_valid=0, controls and out_illegal forced to 0. Any concurrent incoming instruction is dropped (not counted). illegal_count is kept.
  - stall (no flush): all registers hold, including while out_valid=1 and out_ready=1. in_ready=0.
  - transfer: load the decoded bundle, set out_valid=1.
  - drain (out_ready=1 with no transfer): out_valid=0, controls forced to 0.
- Bubble rule: whenever out_valid=0, regwrite, memwrite, branch, jump, jumpreg and out_illegal read 0. Downstream may ignore out_valid for side-effect control.
- illegal_count increments by 1 on each transfer of an illegal instruction. It saturates at 2^CNT_W-1 and never wraps.
- Reset mid-stream: a bundle pending with out_valid=1 is discarded, and no transfer occurs in the reset cycle.
- Purely registered outputs. in_ready is combinational from stall, out_valid and out_ready only.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, all controls 0, illegal_count=0, and no transfer on release edge until rst=0.
- Decode sweep: one transfer each of load, store, R, branch, I-ALU, JAL, JALR, LUI, AUIPC with out_ready=1 -> each bundle matches its table row exactly one cycle later; JALR gives jumpreg=1; AUIPC gives alusrca=1, immsrc=100.
- Illegal and saturation, CNT_W=2: feed opcode 1111111 five times -> out_illegal=1 with controls 0, and illegal_count goes 1, 2, 3, 3, 3.
- Parameter gate, EN_UTYPE=0 and EN_JALR=0: feed LUI, AUIPC, JALR -> out_illegal=1 each, and illegal_count=3.
- Backpressure: out_valid=1 with out_ready=0 -> in_ready=0 and bundle held. Then out_ready=1 with in_valid=1 -> new bundle replaces the old one with no gap.
- Stall and flush: stall=1 with out_ready=1 -> bundle and out_valid held. flush=1 with in_valid=1 carrying an illegal opcode -> out_valid=0 next cycle, regwrite=0, illegal_count unchanged. flush and stall asserted together -> flush wins.
